grid_frame_renderer: RTL



---
 rtl/grid_render_pkg.sv | 36 +++
 rtl/cell_pixel_counter.sv | 107 ++++++++++
 rtl/grid_frame_renderer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/grid_render_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_render_pkg
// Description : Shared types and constants for the grid frame renderer.
//               Holds the frame FSM state encoding, the VGA screen limits,
//               the pixel coordinate widths and the default cell colours.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_render_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Visible area of the VGA adapter
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Pixel coordinate widths on the adapter plot interface
  localparam int X_W = 8;
  localparam int Y_W = 7;

  // Default colours
  localparam logic [2:0] ALIVE_COLOUR_DEF = 3'b100;
  localparam logic [2:0] DEAD_COLOUR_DEF  = 3'b111;

  // Width of a counter covering 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : grid_render_pkg
`default_nettype wire

// File: rtl/cell_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : cell_pixel_counter
// Description : Walks a GRID_W x GRID_H cell grid in row-major order (cx
//               fastest) and, inside each cell, the 2^CELL_LOG2 square of
//               pixel offsets in row-major order (ox fastest).
//   clk, reset     : clock and synchronous active-high reset
//   clear_i        : return all counters to zero
//   inc_i          : advance one step
//   skip_cell_i    : with inc_i, jump straight to the next cell
//   cx_o/cy_o      : current cell column / row
//   ox_o/oy_o      : current pixel offset inside the cell
//   last_pixel_o   : offset is at the final pixel of the cell
//   last_cell_o    : cell is the final cell of the grid
// Revision    : 1.0 - initial release
// ============================================================================
module cell_pixel_counter
  import grid_render_pkg::*;
#(
  parameter int GRID_W    = 8,
  parameter int GRID_H    = 8,
  parameter int CELL_LOG2 = 2,
  localparam int CX_W     = cnt_width(GRID_W),
  localparam int CY_W     = cnt_width(GRID_H),
  localparam int OW       = cnt_width(1 << CELL_LOG2)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            inc_i,
  input  logic            skip_cell_i,
  output logic [CX_W-1:0] cx_o,
  output logic [CY_W-1:0] cy_o,
  output logic [OW-1:0]   ox_o,
  output logic [OW-1:0]   oy_o,
  output logic            last_pixel_o,
  output logic            last_cell_o
);

  localparam logic [CX_W-1:0] C_CX_MAX = CX_W'(GRID_W - 1);
  localparam logic [CY_W-1:0] C_CY_MAX = CY_W'(GRID_H - 1);
  localparam logic [OW-1:0]   C_O_MAX  = OW'((1 << CELL_LOG2) - 1);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  logic [OW-1:0]   ox_q, ox_d;
  logic [OW-1:0]   oy_q, oy_d;

  logic w_last_pixel;
  logic w_last_cell;

  assign w_last_pixel = (ox_q == C_O_MAX) && (oy_q == C_O_MAX);
  assign w_last_cell  = (cx_q == C_CX_MAX) && (cy_q == C_CY_MAX);

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (clear_i) begin
      cx_d = '0;
      cy_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else if (inc_i) begin
      if (skip_cell_i || w_last_pixel) begin
        // Cell finished (or skipped): restart offsets, step to next cell
        ox_d = '0;
        oy_d = '0;
        if (cx_q == C_CX_MAX) begin
          cx_d = '0;
          cy_d = (cy_q == C_CY_MAX) ? '0 : cy_q + CY_W'(1);
        end else begin
          cx_d = cx_q + CX_W'(1);
        end
      end else if (ox_q == C_O_MAX) begin
        ox_d = '0;
        oy_d = oy_q + OW'(1);
      end else begin
        ox_d = ox_q + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  assign cx_o         = cx_q;
  assign cy_o         = cy_q;
  assign ox_o         = ox_q;
  assign oy_o         = oy_q;
  assign last_pixel_o = w_last_pixel;
  assign last_cell_o  = w_last_cell;

endmodule : cell_pixel_counter
`default_nettype wire

// File: rtl/grid_frame_renderer.sv
`default_nettype none
// ============================================================================
// Module      : grid_frame_renderer
// Description : Renders a GRID_W x GRID_H one-bit cell grid as square blocks
//               of 2^CELL_LOG2 pixels onto the VGA adapter plot interface,
//               one pixel per clock. A frame is requested with start; the
//               cell vector is snapshotted at that moment. In difference
//               mode only cells changed since the last completed frame are
//               redrawn; unchanged cells cost a single idle cycle.
//   clk, reset  : clock and synchronous active-high reset
//   start       : frame request, honoured only while idle
//   force_full  : sampled with start, forces a full redraw
//   cells       : cell states, bit index cy*GRID_W + cx
//   busy        : frame in progress
//   done        : one-cycle pulse at frame end
//   plot        : pixel write strobe
//   x, y        : pixel coordinates
//   colour      : pixel colour
// Revision    : 1.0 - initial release
// ============================================================================
module grid_frame_renderer
  import grid_render_pkg::*;
#(
  parameter int         GRID_W       = 8,
  parameter int         GRID_H       = 8,
  parameter int         CELL_LOG2    = 2,
  parameter int         X_OFF        = 0,
  parameter int         Y_OFF        = 0,
  parameter logic [2:0] ALIVE_COLOUR = ALIVE_COLOUR_DEF,
  parameter logic [2:0] DEAD_COLOUR  = DEAD_COLOUR_DEF,
  parameter int         DIFF_MODE    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     force_full,
  input  logic [GRID_W*GRID_H-1:0] cells,
  output logic                     busy,
  output logic                     done,
  output logic                     plot,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [2:0]               colour
);

  localparam int N_CELLS = GRID_W * GRID_H;
  localparam int CX_W    = cnt_width(GRID_W);
  localparam int CY_W    = cnt_width(GRID_H);
  localparam int OW      = cnt_width(1 << CELL_LOG2);
  localparam int IDX_W   = cnt_width(N_CELLS);

  // Refuse to build a grid that would run off the visible screen
  if ((X_OFF + GRID_W * (1 << CELL_LOG2) > SCREEN_W) ||
      (Y_OFF + GRID_H * (1 << CELL_LOG2) > SCREEN_H)) begin : g_geometry_check
    $error("grid_frame_renderer: grid does not fit on the 160x120 screen");
  end

  state_e state_q, state_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [2:0]         colour_q, colour_d;
  logic [N_CELLS-1:0] shadow_q, shadow_d;
  logic [N_CELLS-1:0] prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic               full_q, full_d;

  logic            w_cnt_clear;
  logic            w_cnt_inc;
  logic            w_cnt_skip;
  logic [CX_W-1:0] w_cx;
  logic [CY_W-1:0] w_cy;
  logic [OW-1:0]   w_ox;
  logic [OW-1:0]   w_oy;
  logic            w_last_pixel;
  logic            w_last_cell;
  logic [IDX_W-1:0] w_idx;
  logic            w_need;

  cell_pixel_counter #(
    .GRID_W    (GRID_W),
    .GRID_H    (GRID_H),
    .CELL_LOG2 (CELL_LOG2)
  ) u_counter (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (w_cnt_clear),
    .inc_i        (w_cnt_inc),
    .skip_cell_i  (w_cnt_skip),
    .cx_o         (w_cx),
    .cy_o         (w_cy),
    .ox_o         (w_ox),
    .oy_o         (w_oy),
    .last_pixel_o (w_last_pixel),
    .last_cell_o  (w_last_cell)
  );

  assign w_idx  = IDX_W'(w_cy) * IDX_W'(GRID_W) + IDX_W'(w_cx);
  // A cell is drawn on a full frame or when it differs from the last frame
  assign w_need = full_q | (shadow_q[w_idx] ^ prev_q[w_idx]);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    plot_d       = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    shadow_d     = shadow_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    full_d       = full_q;
    w_cnt_clear  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_cnt_skip   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d    = cells;
          full_d      = force_full | ~prev_valid_q | (DIFF_MODE == 0);
          w_cnt_clear = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_DRAW;
        end
      end

      ST_DRAW: begin
        w_cnt_inc = 1'b1;
        if (w_need) begin
          plot_d   = 1'b1;
          x_d      = X_W'(X_OFF) + (X_W'(w_cx) << CELL_LOG2) + X_W'(w_ox);
          y_d      = Y_W'(Y_OFF) + (Y_W'(w_cy) << CELL_LOG2) + Y_W'(w_oy);
          colour_d = shadow_q[w_idx] ? ALIVE_COLOUR : DEAD_COLOUR;
          if (w_last_pixel && w_last_cell) begin
            state_d = ST_FINISH;
          end
        end else begin
          // Unchanged cell: one silent cycle, pixel outputs hold
          w_cnt_skip = 1'b1;
          if (w_last_cell) begin
            state_d = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        done_d       = 1'b1;
        busy_d       = 1'b0;
        prev_d       = shadow_q;
        prev_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      shadow_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      shadow_q     <= shadow_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      full_q       <= full_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule : grid_frame_renderer
`default_nettype wire
